// File: rtl/load_use_interlock.sv
// ---------------------------------------------------------------------------
// load_use_interlock
//
// Pipeline interlock controller for the hazards the forwarding network cannot
// cover. It compares the decoded instruction in ID against the instruction in
// EX. It then drives the PC / IF-ID freeze, ID/EX bubble insertion and the
// taken-branch flush. It also keeps saturating stall and flush event counters
// for performance debug.
//
// Register field packing (W = REG_ADDR_WIDTH), for both rf_id and rf_ex:
//   [3W+2] Rw_d  [3W+1] Rw_n  [3W] Rw_m  (the field is really defined or used)
//   [3W-1:2W] Rd  [2W-1:W] Rn  [W-1:0] Rm
// Flag packing, for both mf_id and mf_ex:
//   {BLS, BS, 0, DPF, MWE, WBS, IS, RFWE}
//
// Ports:
//   clk, rst        pipeline clock, synchronous active-high reset
//   rf_id/mf_id     ID-stage register fields and flags
//   vf_id           ID holds a valid instruction
//   rf_ex/mf_ex     EX-stage register fields and flags
//   vf_ex           EX holds a valid instruction
//   branch_taken    branch in EX resolved taken this cycle
//   cnt_clr         synchronous clear of both event counters
//   pc_stall        hold PC this cycle
//   ifid_stall      hold the IF/ID register this cycle
//   idex_bubble     load a NOP (valid=0) into ID/EX this cycle
//   flush_ifid      invalidate IF/ID contents this cycle
//   state           current FSM state: 0 RUN, 1 LSTALL, 2 FLUSH
//   stall_cnt       number of load-use stalls taken (saturating)
//   flush_cnt       number of taken-branch flushes (saturating)
//
// Handshake / timing contract: there is no valid/ready handshake here. All
// control outputs are combinational from the current inputs and the
// registered state. They are valid in the same cycle the hazard is presented,
// and the pipeline consumes them at the next rising edge of clk. While rst is
// high, every control output is held at 0.
// ---------------------------------------------------------------------------
module load_use_interlock #(
    parameter int REG_ADDR_WIDTH = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3*REG_ADDR_WIDTH+2:0] rf_id,
    input  logic [7:0]                  mf_id,
    input  logic                        vf_id,
    input  logic [3*REG_ADDR_WIDTH+2:0] rf_ex,
    input  logic [7:0]                  mf_ex,
    input  logic                        vf_ex,
    input  logic                        branch_taken,
    input  logic                        cnt_clr,
    output logic                        pc_stall,
    output logic                        ifid_stall,
    output logic                        idex_bubble,
    output logic                        flush_ifid,
    output logic [1:0]                  state,
    output logic [CNT_WIDTH-1:0]        stall_cnt,
    output logic [CNT_WIDTH-1:0]        flush_cnt
);

    localparam int W = REG_ADDR_WIDTH;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Flag bit positions inside mf_*.
    localparam int MF_MWE  = 3;
    localparam int MF_WBS  = 2;
    localparam int MF_RFWE = 0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [W-1:0] rd_ex;
    logic         rwd_ex;
    logic [W-1:0] rn_id;
    logic [W-1:0] rm_id;
    logic         rwn_id;
    logic         rwm_id;

    assign rd_ex  = rf_ex[3*W-1:2*W];
    assign rwd_ex = rf_ex[3*W+2];
    assign rn_id  = rf_id[2*W-1:W];
    assign rm_id  = rf_id[W-1:0];
    assign rwn_id = rf_id[3*W+1];
    assign rwm_id = rf_id[3*W];

    // Fields that play no part in the interlock decision are collected here
    // so that it is explicit they are ignored on purpose.
    logic unused_fields;
    assign unused_fields = ^{rf_id[3*W+2], rf_id[3*W-1:2*W],
                             rf_ex[3*W+1:3*W], rf_ex[2*W-1:0],
                             mf_id[7:4], mf_id[2:0],
                             mf_ex[7:3], mf_ex[1]};

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic load_in_ex;
    logic conflict;
    logic load_use;
    logic flush_ev;
    logic stall_ev;

    always_comb begin
        // A load is a valid EX instruction that writes the register file
        // from the memory stage into a really defined destination.
        load_in_ex = vf_ex & mf_ex[MF_WBS] & mf_ex[MF_RFWE] & rwd_ex;

        // Only the source fields that ID actually reads count as a match.
        conflict = ((rd_ex == rn_id) & rwn_id) |
                   ((rd_ex == rm_id) & rwm_id);

        // A store consumer is served by the WB->MEM bypass and never stalls.
        load_use = load_in_ex & vf_id & conflict & ~mf_id[MF_MWE];

        // A taken branch is honoured in any state and overrides a load-use
        // stall in the same cycle, because the stalled slot is squashed anyway.
        flush_ev = ~rst & branch_taken & vf_ex;

        // Load-use detection runs only in RUN. In LSTALL the load has already
        // cost its bubble, and in FLUSH the ID slot holds a squashed
        // instruction.
        stall_ev = ~rst & load_use & (state_q == ST_RUN) & ~flush_ev;
    end

    // ------------------------------------------------------------------
    // Control outputs (combinational, zero-latency)
    // ------------------------------------------------------------------
    always_comb begin
        pc_stall    = stall_ev;
        ifid_stall  = stall_ev;
        idex_bubble = stall_ev | flush_ev;
        flush_ifid  = flush_ev;
    end

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = ST_RUN;
        if (flush_ev) begin
            // Includes FLUSH -> FLUSH on back-to-back taken branches.
            state_d = ST_FLUSH;
        end else if (stall_ev) begin
            state_d = ST_LSTALL;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        // A clear wins over an increment in the same cycle.
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_ev && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            if (flush_ev && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/load_use_interlock.md
# load_use_interlock

Pipeline interlock controller that acts on the hazards the forwarding network cannot cover. It sits beside the ID/EX pipeline registers, compares the decoded instruction in ID against the instruction in EX, and drives PC/IF-ID freeze, ID/EX bubble insertion and taken-branch flush. It also keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- REG_ADDR_WIDTH, 4, register address width
- CNT_WIDTH, 16, width of each event counter

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  pipeline clock
  - rst  in  1  synchronous reset, active-high
- rf_id  in  3*REG_ADDR_WIDTH+3  ID-stage register fields {Rw_d, Rw_n, Rw_m, Rd, Rn, Rm}; Rw_* bits [14:12] mark the field as really used or defined
- mf_id  in  8  ID-stage flags {BLS, BS, 0, DPF, MWE, WBS, IS, RFWE}
- vf_id  in  1  ID holds a valid instruction
- rf_ex  in  3*REG_ADDR_WIDTH+3  EX-stage register fields, same packing
- mf_ex  in  8  EX-stage flags, same packing
- vf_ex  in  1  EX holds a valid instruction
- branch_taken  in  1  branch in EX resolved taken this cycle
- cnt_clr  in  1  synchronous clear of both counters
- pc_stall  out  1  hold PC this cycle
- ifid_stall  out  1  hold IF/ID register this cycle
- idex_bubble  out  1  load a NOP (valid=0) into ID/EX this cycle
- flush_ifid  out  1  invalidate IF/ID contents this cycle
- state  out  2  current FSM state: 0 RUN, 1 LSTALL, 2 FLUSH
- stall_cnt  out  CNT_WIDTH  load-use stalls taken
- flush_cnt  out  CNT_WIDTH  taken-branch flushes

## Operation
- Load in EX: vf_ex & mf_ex[2] (WBS) & mf_ex[0] (RFWE) & rf_ex[14].
- Conflict: rf_ex[11:8] equals Rn_id with rf_id[13] set, or equals Rm_id with rf_id[12] set.
- Load-use hazard: load in EX & vf_id & conflict & not mf_id[3] (MWE). A store consumer never stalls because the WB->MEM bypass serves it.
- Flush: branch_taken & vf_ex. It drives flush_ifid=1 and idex_bubble=1. Flush overrides a load-use hazard in the same cycle: no stall outputs, no stall count.
- Stall: load-use hazard in RUN, with no flush, drives pc_stall=ifid_stall=idex_bubble=1.
- Outputs are combinational from current inputs and state. All of them are forced to 0 while rst=1.
- FSM, registered on clk:
  - RUN -> FLUSH on flush.
  - RUN -> LSTALL on stall.
  - Otherwise RUN stays in RUN.
  - LSTALL -> RUN after one cycle, or -> FLUSH if flush occurs. Load-use detection is suppressed in LSTALL, so each load costs at most one bubble.
  - FLUSH -> RUN after one cycle. Load-use detection is suppressed in FLUSH because ID holds a squashed slot. A new flush in FLUSH re-enters FLUSH.
- Counters:
  - stall_cnt increments on each cycle the stall outputs assert.
  - flush_cnt increments on each flush cycle.
  - Both saturate at 2^CNT_WIDTH-1 and do not wrap.
  - cnt_clr zeroes both. It takes priority over an increment in the same cycle, so the counter reads 0 next cycle.

## Timing
- Reset: state=RUN(0), stall_cnt=0, flush_cnt=0 on the first clk edge with rst=1. Combinational outputs are 0 for the whole time rst is high.
- Stall latency:
  - Zero cycles: outputs assert in the same cycle the load sits in EX and the consumer sits in ID.
  - Exactly one stall cycle per load.
  - The cycle after the stall shows state=LSTALL with all stall outputs 0.
- Flush latency: zero cycles, one cycle wide per taken branch. state=FLUSH the following cycle.
- Reset mid-stall or mid-flush: rst in LSTALL or FLUSH returns the FSM to RUN at the next edge with no residual outputs. Counters are cleared.
- All state changes occur on the rising edge of clk only. No other clock, enable or asynchronous path exists.

## Test plan
- Load-use stall: LDR R1 in EX (mf_ex=0x05, rf_ex Rd=1, Rw_d=1), ADD R2,R3,R1 in ID (Rm=1, Rw_m=1). Required: pc_stall=ifid_stall=idex_bubble=1 for one cycle, then LSTALL with outputs 0, then RUN, stall_cnt=1.
- Store consumer: same LDR in EX, STR R1,[R2] in ID (mf_id MWE=1). Required: no outputs, state stays RUN, stall_cnt=0.
- Unused field: LDR R0 in EX, ID instruction with Rm=0 but Rw_m=0 and Rn=5. Required: no stall.
- Branch vs hazard: branch_taken=1 with vf_ex=1 while a load-use pattern is presented. Required: flush_ifid=idex_bubble=1, pc_stall=0, flush_cnt=1, stall_cnt=0, FLUSH for one cycle, then RUN.
- Saturation and clear, with CNT_WIDTH=4:
  - 17 consecutive separated load-use stalls: stall_cnt=15.
  - cnt_clr together with a stall: stall_cnt=0 next cycle.
- Reset mid-operation: assert rst during LSTALL. Required: outputs 0 immediately, state=RUN and both counters 0 after the edge.
